// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the four raw mole buttons for the game core. Each button gets a
// 2-flop synchroniser and a debounce FSM. The FSM changes the clean level only
// after DEBOUNCE_CYCLES consecutive agreeing synchronised samples. It emits
// registered press/release pulses and a combinational priority-encoded hit
// strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronised samples needed to change level (2..255)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk         in  1  system clock, rising edge
//   rst_n       in  1  asynchronous active-low reset
//   btn_raw     in  4  raw asynchronous buttons, bit i = mole i
//   btn_level   out 4  debounced levels
//   btn_press   out 4  one-cycle pulse on debounced 0->1
//   btn_release out 4  one-cycle pulse on debounced 1->0
//   hit_valid   out 1  any btn_press bit high
//   hit_idx     out 2  lowest set btn_press bit (valid with hit_valid)
//   hit_multi   out 1  more than one btn_press bit high
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       hit_valid,
  output logic [1:0] hit_idx,
  output logic       hit_multi
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYCLES must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE,    // level 0, nothing pending
    ARM_HI,  // level 0, qualifying a rise
    HELD,    // level 1, nothing pending
    ARM_LO   // level 1, qualifying a fall
  } state_e;

  // The count reaches this value on the last qualifying sample. It never
  // goes past it, so the counter cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       s;
  state_e           state_q [4];
  state_e           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       level_q,   level_d;
  logic [3:0]       press_q,   press_d;
  logic [3:0]       release_q, release_d;

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge value. This is what makes the two sync stages a
  // real 2-flop chain rather than a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  // NOTE: the per-channel state and counter arrays are plain flops, not RAM.
  // They are all reset, so a reset in mid-qualification abandons the count
  // and every channel restarts from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // NOTE: every signal assigned here gets a default first. An FSM path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = ARM_HI;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ARM_HI: begin
          if (!s[i]) begin
            // Any disagreeing sample throws away the partial count.
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d[i] = ARM_LO;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ARM_LO: begin
          if (s[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = IDLE;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  // Bit 0 has the highest priority. The loop runs from the top down, so the
  // last assignment made is the one for the lowest set bit.
  always_comb begin
    hit_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (press_q[i]) hit_idx = 2'(i);
    end
  end

  assign hit_valid = |press_q;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign hit_multi = |(press_q & (press_q - 4'd1));

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage directly upstream of the whack-a-mole game core (`main`). It takes the four raw, bouncy mole buttons, synchronises and debounces each one, and emits a clean level plus a single-cycle press pulse per button. It also provides an encoded "hit" strobe, so the game core scores at most one press per button per physical push.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before the debounced level changes. Legal range is 2..255.
- `CNT_W`, default 8: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1: single system clock; all state is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_raw`  in  4: raw asynchronous buttons; bit i is mole i (in1 maps to bit 0).
- `btn_level`  out  4: debounced button levels.
- `btn_press`  out  4: one-cycle pulse on each debounced 0->1 transition.
- `btn_release`  out  4: one-cycle pulse on each debounced 1->0 transition.
- `hit_valid`  out  1: asserted whenever any `btn_press` bit is high.
- `hit_idx`  out  2: index of the lowest set `btn_press` bit. Valid only with `hit_valid`.
- `hit_multi`  out  1: more than one `btn_press` bit is high in the same cycle.

## Operation
- Each channel has a 2-flop synchroniser on `btn_raw[i]`, producing `s[i]`.
- Each channel runs a 4-state FSM with a counter `cnt`:
  - IDLE (level 0): on `s=1`, set `cnt=1` and go to ARM_HI.
  - ARM_HI: if `s=0`, clear `cnt` and return to IDLE. If `s=1` and `cnt==DEBOUNCE_CYCLES-1`, go to HELD, set level to 1 and pulse press. Otherwise increment `cnt`.
  - HELD (level 1): on `s=0`, set `cnt=1` and go to ARM_LO.
  - ARM_LO: mirror of ARM_HI. Reaching the count goes to IDLE, clears level and pulses release. If `s=1`, return to HELD.
- Any sample that disagrees with the pending direction restarts the qualification from zero. No partial credit is kept.
- `btn_press`, `btn_release` and `btn_level` are registered.
- `hit_valid`, `hit_idx` and `hit_multi` are combinational decodes of the registered `btn_press`:
  - priority is bit 0 highest;
  - lower-priority simultaneous presses remain visible on `btn_press` but are not encoded.
- A button held indefinitely produces exactly one press. No auto-repeat.
- Channels are fully independent. One channel's activity never delays or suppresses another.

## Timing
- Reset (async assert, sync-safe deassert by upstream reset logic) drives:
  - synchronisers and `btn_level` to 4'b0000;
  - all FSMs to IDLE with `cnt=0`;
  - `btn_press` and `btn_release` to 0;
  - `hit_valid`, `hit_idx` and `hit_multi` to 0.
- Press latency: `btn_raw[i]` rises and is stable before edge 0.
  - `s[i]` is 1 after edge 1.
  - `btn_level[i]` and `btn_press[i]` go high after edge `DEBOUNCE_CYCLES+1`.
  - `btn_press[i]` drops after the next edge.
- Release latency is identical, measured to `btn_release`.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` clocks of stable raw level (±1 clock for synchroniser phase). Shorter glitches produce no level change and no pulses.
- Reset asserted mid-qualification abandons the count. After release, a still-held button must requalify from IDLE for the full `DEBOUNCE_CYCLES`, then generates one press.
- Counter never wraps. It is bounded by `DEBOUNCE_CYCLES-1`, and `CNT_W` is checked by assertion at elaboration.
- After a press, `btn_press[i]` cannot reassert until a qualified release has occurred, i.e. at least `2*DEBOUNCE_CYCLES` clocks later.

## Test plan
- Clean press, D=4: `btn_raw=4'b0001` held 10 clocks from edge 0.
  - `btn_press[0]` high for exactly the cycle after edge 5, `hit_valid=1`, `hit_idx=0`, `hit_multi=0`.
  - `btn_level[0]` stays 1 until release.
- Bounce rejection, D=4: `btn_raw[2]` toggles 1 for 3 clk, 0 for 2, 1 for 2, 0 for 1, 1 for 1, 0.
  - No `btn_press` or `btn_release`, and `btn_level[2]` stays 0 throughout.
- Bounce then settle: same bounce pattern followed by `btn_raw[2]=1` held for 8 clk.
  - Exactly one `btn_press[2]`, occurring 5 edges after the final rising raw edge, with `hit_idx=2`.
- Release: after the scenario 1 press, drop `btn_raw[0]` for 6 clk.
  - One `btn_release[0]` pulse 5 edges after the drop; `btn_level[0]` goes to 0; no extra press.
- Simultaneous: `btn_raw=4'b1010` rising on the same edge and held.
  - `btn_press=4'b1010` for one cycle, `hit_valid=1`, `hit_idx=1`, `hit_multi=1`.
- Reset mid-count: hold `btn_raw[3]=1`, pulse `rst_n` low at edge 3 for 1 clk.
  - All outputs go to 0 immediately.
  - `btn_press[3]` occurs `DEBOUNCE_CYCLES+1` edges after reset release, exactly once.
